// File: rtl/reference_pulse_generator.sv
// Periodic reference-pulse transmitter with programmable period, width, phase and pulse count.
// Optional external sync arming is enabled by defining REF_PULSE_EXT_SYNC_EN.
module reference_pulse_generator #(
  parameter int PERIOD_WIDTH = 32,
  parameter int LENGTH_WIDTH = 16,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    stop,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [LENGTH_WIDTH-1:0] pulse_length,
  input  logic [PERIOD_WIDTH-1:0] phase_offset,
  input  logic [COUNT_WIDTH-1:0]  num_pulses,
`ifdef REF_PULSE_EXT_SYNC_EN
  input  logic                    sync_in,
`endif
  output logic                    pulse_out,
  output logic                    period_tick,
  output logic                    running,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  pulse_count
);

  // state  | meaning
  // IDLE   | held off, waiting for start
  // ARMED  | (optionally waiting for sync edge) counting down phase offset
  // RUN    | emitting periods, cnt_q counts up within the period
  // DONE   | requested number of periods emitted, outputs quiet

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] PER_TWO = PERIOD_WIDTH'(2);
  localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = COUNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] off_q, off_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] len_q, len_d;
  logic [COUNT_WIDTH-1:0]  num_q, num_d;
  logic [COUNT_WIDTH-1:0]  count_d;
  logic                    pulse_d, tick_d, arm;

  logic [PERIOD_WIDTH-1:0] period_eff, len_ext, len_eff;

  assign period_eff = (period < PER_TWO) ? PER_TWO : period;
  assign len_ext    = PERIOD_WIDTH'(pulse_length);
  assign len_eff    = (len_ext >= period_eff) ? (period_eff - PER_ONE) : len_ext;

`ifdef REF_PULSE_EXT_SYNC_EN
  logic sync_ff1, sync_ff2, sync_d, sync_rise_q;
  logic wait_q, wait_d;

  // Registered edge detect adds one cycle so the first pulse lands offset+4 after the pin edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff1    <= 1'b0;
      sync_ff2    <= 1'b0;
      sync_d      <= 1'b0;
      sync_rise_q <= 1'b0;
    end else begin
      sync_ff1    <= sync_in;
      sync_ff2    <= sync_ff1;
      sync_d      <= sync_ff2;
      sync_rise_q <= sync_ff2 & ~sync_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    period_d = period_q;
    len_d    = len_q;
    num_d    = num_q;
    count_d  = pulse_count;
    pulse_d  = 1'b0;
    tick_d   = 1'b0;
    arm      = 1'b0;
`ifdef REF_PULSE_EXT_SYNC_EN
    wait_d   = wait_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !stop) arm = 1'b1;
      end
      S_ARMED: begin
        if (stop) state_d = S_IDLE;
`ifdef REF_PULSE_EXT_SYNC_EN
        else if (wait_q) wait_d = ~sync_rise_q;
`endif
        else if (off_q == '0) begin
          state_d = S_RUN;
          cnt_d   = '0;
          tick_d  = 1'b1;
          pulse_d = (len_q != '0);
        end else begin
          off_d = off_q - PER_ONE;
        end
      end
      S_RUN: begin
        if (stop) state_d = S_IDLE;
        else if (cnt_q == period_q - PER_ONE) begin
          count_d = pulse_count + CNT_ONE;
          if ((num_q != '0) && (count_d == num_q)) begin
            state_d = S_DONE;
          end else begin
            // Config only changes at period boundaries so a period is never cut short.
            cnt_d    = '0;
            tick_d   = 1'b1;
            period_d = period_eff;
            len_d    = len_eff;
            num_d    = num_pulses;
            pulse_d  = (len_eff != '0);
          end
        end else begin
          cnt_d   = cnt_q + PER_ONE;
          pulse_d = (cnt_d < len_q);
        end
      end
      S_DONE: begin
        if (stop) state_d = S_IDLE;
        else if (start) arm = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (arm) begin
      state_d  = S_ARMED;
      period_d = period_eff;
      len_d    = len_eff;
      num_d    = num_pulses;
      off_d    = phase_offset;
      count_d  = '0;
`ifdef REF_PULSE_EXT_SYNC_EN
      wait_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      period_q    <= '0;
      len_q       <= '0;
      num_q       <= '0;
      pulse_count <= '0;
      pulse_out   <= 1'b0;
      period_tick <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      period_q    <= period_d;
      len_q       <= len_d;
      num_q       <= num_d;
      pulse_count <= count_d;
      pulse_out   <= pulse_d;
      period_tick <= tick_d;
      running     <= (state_d == S_ARMED) || (state_d == S_RUN);
      done        <= (state_d == S_DONE);
    end
  end

`ifdef REF_PULSE_EXT_SYNC_EN
  always_ff @(posedge clk) begin
    if (reset || !enable) wait_q <= 1'b0;
    else                  wait_q <= wait_d;
  end
`endif

endmodule

// File: tb/tb_reference_pulse_generator.sv
// Directed self-checking bench for reference_pulse_generator.
// Edge numbering: the edge that samples start is edge 0; outputs are sampled 1 time unit after each edge.
module tb_reference_pulse_generator;

  logic        clk = 1'b0;
  logic        reset, enable, start, stop;
  logic [31:0] period, phase_offset, num_pulses;
  logic [15:0] pulse_length;
  logic        pulse_out, period_tick, running, done;
  logic [31:0] pulse_count;
`ifdef REF_PULSE_EXT_SYNC_EN
  logic        sync_in;
`endif

  int errors = 0;
  int checks = 0;

  reference_pulse_generator dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .stop         (stop),
    .period       (period),
    .pulse_length (pulse_length),
    .phase_offset (phase_offset),
    .num_pulses   (num_pulses),
`ifdef REF_PULSE_EXT_SYNC_EN
    .sync_in      (sync_in),
`endif
    .pulse_out    (pulse_out),
    .period_tick  (period_tick),
    .running      (running),
    .done         (done),
    .pulse_count  (pulse_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", pulse_out); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", period_tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pulse_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", pulse_count); end
    reset  = 1'b0;
    enable = 1'b0;
    do_start();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL disabled_start: running got %b want 0", running); end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_continuous();
    logic ep, et;
    period = 10; pulse_length = 3; phase_offset = 0; num_pulses = 0;
    do_start();
    for (int k = 1; k <= 25; k++) begin
      if (k == 15) start = 1'b1;  // start during RUN must be ignored
      tick();
      start = 1'b0;
      ep = ((k - 1) % 10) < 3;
      et = ((k - 1) % 10) == 0;
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL cont_pulse edge %0d: got %b want %b", k, pulse_out, ep); end
      checks++; if (period_tick !== et) begin errors++; $display("FAIL cont_tick edge %0d: got %b want %b", k, period_tick, et); end
      if (k == 11) begin
        checks++; if (pulse_count !== 32'd1) begin errors++; $display("FAIL cont_count edge 11: got %0d want 1", pulse_count); end
      end
    end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL cont_running: got %b want 1", running); end
    do_stop();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL cont_stop_running: got %b want 0", running); end
    checks++; if (pulse_count !== 32'd2) begin errors++; $display("FAIL cont_stop_count: got %0d want 2", pulse_count); end
  endtask

  task automatic test_finite();
    logic ep, et, er, ed;
    int ec, rel;
    period = 8; pulse_length = 2; phase_offset = 5; num_pulses = 3;
    do_start();
    for (int k = 1; k <= 32; k++) begin
      tick();
      rel = k - 6;
      if (k < 6) begin
        ep = 0; et = 0; er = 1; ed = 0; ec = 0;
      end else if (k < 30) begin
        ep = (rel % 8) < 2; et = (rel % 8) == 0; er = 1; ed = 0; ec = rel / 8;
      end else begin
        ep = 0; et = 0; er = 0; ed = 1; ec = 3;
      end
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL fin_pulse edge %0d: got %b want %b", k, pulse_out, ep); end
      checks++; if (period_tick !== et) begin errors++; $display("FAIL fin_tick edge %0d: got %b want %b", k, period_tick, et); end
      checks++; if (running !== er) begin errors++; $display("FAIL fin_running edge %0d: got %b want %b", k, running, er); end
      checks++; if (done !== ed) begin errors++; $display("FAIL fin_done edge %0d: got %b want %b", k, done, ed); end
      checks++; if (pulse_count !== 32'(ec)) begin errors++; $display("FAIL fin_count edge %0d: got %0d want %0d", k, pulse_count, ec); end
    end
    do_start();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL rearm_running: got %b want 1", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rearm_done: got %b want 0", done); end
    checks++; if (pulse_count !== 32'd0) begin errors++; $display("FAIL rearm_count: got %0d want 0", pulse_count); end
    do_stop();
  endtask

  task automatic test_period_change();
    logic ep, et;
    period = 10; pulse_length = 3; phase_offset = 0; num_pulses = 0;
    do_start();
    for (int k = 1; k <= 52; k++) begin
      tick();
      et = (k == 1) || (k == 11) || (k == 31) || (k == 51);
      ep = (k <= 3) || (k >= 11 && k <= 13) || (k >= 31 && k <= 33) || (k >= 51);
      checks++; if (period_tick !== et) begin errors++; $display("FAIL pchg_tick edge %0d: got %b want %b", k, period_tick, et); end
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL pchg_pulse edge %0d: got %b want %b", k, pulse_out, ep); end
      if (k == 5) period = 20;
    end
    do_stop();
    period = 10;
  endtask

  task automatic test_stop();
    period = 10; pulse_length = 3; phase_offset = 0; num_pulses = 0;
    do_start();
    for (int k = 1; k <= 12; k++) tick();
    checks++; if (pulse_out !== 1'b1) begin errors++; $display("FAIL stop_pre_pulse: got %b want 1", pulse_out); end
    do_stop();
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL stop_pulse: got %b want 0", pulse_out); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b want 0", running); end
    checks++; if (pulse_count !== 32'd1) begin errors++; $display("FAIL stop_count: got %0d want 1", pulse_count); end
    tick(); tick(); tick();
    checks++; if (pulse_count !== 32'd1) begin errors++; $display("FAIL stop_hold_count: got %0d want 1", pulse_count); end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL startstop_running: got %b want 0", running); end
    tick();
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL startstop_pulse: got %b want 0", pulse_out); end
    checks++; if (pulse_count !== 32'd1) begin errors++; $display("FAIL startstop_count: got %0d want 1", pulse_count); end
  endtask

  task automatic test_clamps();
    logic ep, et;
    period = 1; pulse_length = 5; phase_offset = 0; num_pulses = 0;
    do_start();
    for (int k = 1; k <= 8; k++) begin
      tick();
      ep = ((k - 1) % 2) == 0;
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL clamp_pulse edge %0d: got %b want %b", k, pulse_out, ep); end
      checks++; if (period_tick !== ep) begin errors++; $display("FAIL clamp_tick edge %0d: got %b want %b", k, period_tick, ep); end
    end
    do_stop();
    period = 4; pulse_length = 0;
    do_start();
    for (int k = 1; k <= 12; k++) begin
      tick();
      et = ((k - 1) % 4) == 0;
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL len0_pulse edge %0d: got %b want 0", k, pulse_out); end
      checks++; if (period_tick !== et) begin errors++; $display("FAIL len0_tick edge %0d: got %b want %b", k, period_tick, et); end
    end
    checks++; if (pulse_count !== 32'd2) begin errors++; $display("FAIL len0_count: got %0d want 2", pulse_count); end
    do_stop();
  endtask

  task automatic test_reset_mid();
    period = 10; pulse_length = 3; phase_offset = 0; num_pulses = 0;
    do_start();
    for (int k = 1; k <= 12; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL rstrun_pulse: got %b want 0", pulse_out); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rstrun_running: got %b want 0", running); end
    checks++; if (pulse_count !== 32'd0) begin errors++; $display("FAIL rstrun_count: got %0d want 0", pulse_count); end
    phase_offset = 5;
    do_start();
    tick(); tick();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL armed_running: got %b want 1", running); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rstarm_running: got %b want 0", running); end
    tick();
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL rstarm_pulse: got %b want 0", pulse_out); end
    phase_offset = 0;
    do_start();
    for (int k = 1; k <= 12; k++) tick();
    enable = 1'b0;
    tick();
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL en_pulse: got %b want 0", pulse_out); end
    checks++; if (pulse_count !== 32'd0) begin errors++; $display("FAIL en_count: got %0d want 0", pulse_count); end
    enable = 1'b1;
    tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL en_idle_running: got %b want 0", running); end
  endtask

`ifdef REF_PULSE_EXT_SYNC_EN
  task automatic test_sync();
    logic ep;
    period = 10; pulse_length = 3; phase_offset = 2; num_pulses = 0;
    sync_in = 1'b0;
    do_start();
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL sync_wait_pulse edge %0d: got %b want 0", k, pulse_out); end
    end
    sync_in = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      ep = (j >= 7);
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL sync_pulse step %0d: got %b want %b", j, pulse_out, ep); end
    end
    do_stop();
    sync_in = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0;
    period = 10; pulse_length = 3; phase_offset = 0; num_pulses = 0;
`ifdef REF_PULSE_EXT_SYNC_EN
    sync_in = 1'b0;
`endif
    test_reset();
`ifdef REF_PULSE_EXT_SYNC_EN
    test_sync();
`else
    test_continuous();
    test_finite();
    test_period_change();
    test_stop();
    test_clamps();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
